img_stream_driver: RTL and testbench
====================================

IMG_STREAM_DRIVER -- requirements
Module: img_stream_driver

Interface
REQ-001 SHALL have parameter DATA_RES, default 8, meaning pixel and result width in bits.
REQ-002 SHALL have parameter IM_DIM, default 28, meaning square input image side in pixels.
REQ-003 SHALL have parameter KERNEL_WIDTH, default 3, meaning convolution kernel side; OUT_WORDS = (IM_DIM-KERNEL_WIDTH+1)^2 and IN_WORDS = IM_DIM^2.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning idle cycles allowed in DRAIN before abort.
REQ-005 SHALL have port clk_i, input, 1, system clock; all logic on rising edge.
REQ-006 SHALL have port resetn_i, input, 1, reset: asynchronous, active-high (resetn_i=1 resets).
REQ-007 SHALL have port wr_en_i, input, 1, frame-buffer write strobe.
REQ-008 SHALL have port wr_addr_i, input, 10, frame-buffer write address.
REQ-009 SHALL have port wr_data_i, input, DATA_RES, frame-buffer write data.
REQ-010 SHALL have port start_i, input, 1, start-frame pulse.
REQ-011 SHALL have port rd_addr_i, input, 10, result-buffer read address.
REQ-012 SHALL have port rd_data_o, output, DATA_RES, result-buffer read data, registered, 1-cycle latency.
REQ-013 SHALL have port busy_o, output, 1, high in SEND or DRAIN.
REQ-014 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port err_o, output, 1, sticky framing/timeout error, cleared on start.
REQ-016 SHALL have port rx_count_o, output, 10, results captured this frame.
REQ-017 SHALL have ports m_axis_tvalid/m_axis_tready/m_axis_tlast (1 bit, out/in/out) and m_axis_tdata (out, DATA_RES): pixel stream to CNN.
REQ-018 SHALL have ports s_axis_tvalid/s_axis_tlast (in, 1), s_axis_tready (out, 1), s_axis_tdata (in, DATA_RES): result stream from CNN.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, DRAIN, DONE.
REQ-020 IDLE: wr_en_i writes wr_data_i to frame buffer at wr_addr_i when wr_addr_i < IN_WORDS; out-of-range and non-IDLE writes ignored.
REQ-021 IDLE & start_i -> SEND next cycle; tx_idx=0, rx_count_o=0, err_o=0, idle timer=0.
REQ-022 start_i in any state other than IDLE SHALL be ignored.
REQ-023 SEND: m_axis_tvalid asserted with m_axis_tdata = frame[tx_idx]; tdata, tvalid, tlast held stable while tvalid & !tready.
REQ-024 tx_idx advances only on m_axis_tvalid & m_axis_tready; no bubbles when tready held high (one pixel per cycle).
REQ-025 m_axis_tlast SHALL be 1 exactly on the beat with tx_idx = IN_WORDS-1.
REQ-026 Handshake of the tlast beat -> DRAIN; m_axis_tvalid low next cycle.
REQ-027 s_axis_tready = 1 in SEND and DRAIN while rx_count_o < OUT_WORDS, else 0.
REQ-028 On s_axis_tvalid & s_axis_tready: store s_axis_tdata at result[rx_count_o], increment rx_count_o.
REQ-029 err_o set if an accepted beat has s_axis_tlast=1 and rx_count_o != OUT_WORDS-1, or tlast=0 and rx_count_o = OUT_WORDS-1.
REQ-030 DRAIN: idle timer counts cycles without an accepted result beat, reset on each beat; reaching TIMEOUT sets err_o -> DONE.
REQ-031 DRAIN & rx_count_o = OUT_WORDS -> DONE; results arriving in SEND count identically.
REQ-032 DONE: done_o=1 for exactly one cycle -> IDLE.
REQ-033 Result buffer read port SHALL operate in every state.

Reset
REQ-034 resetn_i=1 SHALL immediately force IDLE, all outputs 0 (m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, busy_o, done_o, err_o, rx_count_o, rd_data_o), counters 0.
REQ-035 Frame and result buffer contents SHALL be retained across reset; reset mid-frame aborts without done_o.

Verification (IM_DIM=4, KERNEL_WIDTH=3: IN_WORDS=16, OUT_WORDS=4)
REQ-036 Load frame[i]=i, start, tready=1, sink returns 4 beats 0xA0..0xA3, tlast on 4th -> 16 pixels 0..15 in 16 consecutive cycles, tlast on 15, done_o pulse, rd_data_o at addr 2 = 0xA2, err_o=0.
REQ-037 tready toggled 1/0 every cycle in SEND -> each pixel held while stalled, sequence 0..15 unchanged, no duplicates.
REQ-038 Sink asserts tlast on 3rd result -> err_o=1, frame continues to done_o after 4th beat.
REQ-039 Sink returns only 2 results -> after TIMEOUT idle cycles in DRAIN, err_o=1, done_o pulse, rx_count_o=2.
REQ-040 resetn_i=1 at pixel 7 -> all outputs 0 next cycle; new start resends pixel 0 with retained frame data.
REQ-041 wr_en_i and start_i pulsed during SEND -> frame buffer unchanged, no restart, single done_o.

Source files
------------

// File: rtl/img_stream_driver.sv
// img_stream_driver: holds one IM_DIM x IM_DIM frame, streams it to the CNN
// over an AXI-Stream master, and collects the (IM_DIM-KERNEL_WIDTH+1)^2
// results from an AXI-Stream slave into a readable result buffer.
// Framing errors and a DRAIN-phase idle timeout raise a sticky err_o.
module img_stream_driver #(
    parameter int unsigned DATA_RES     = 8,
    parameter int unsigned IM_DIM       = 28,
    parameter int unsigned KERNEL_WIDTH = 3,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                clk_i,
    input  logic                resetn_i,
    input  logic                wr_en_i,
    input  logic [9:0]          wr_addr_i,
    input  logic [DATA_RES-1:0] wr_data_i,
    input  logic                start_i,
    input  logic [9:0]          rd_addr_i,
    output logic [DATA_RES-1:0] rd_data_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [9:0]          rx_count_o,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [DATA_RES-1:0] m_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic [DATA_RES-1:0] s_axis_tdata
);

    localparam int unsigned IN_WORDS  = IM_DIM * IM_DIM;
    localparam int unsigned OUT_DIM   = IM_DIM - KERNEL_WIDTH + 1;
    localparam int unsigned OUT_WORDS = OUT_DIM * OUT_DIM;
    localparam int unsigned FAW       = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int unsigned RAW       = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam int unsigned TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [10:0]   IN_LIMIT     = 11'(IN_WORDS);
    localparam logic [10:0]   OUT_LIMIT    = 11'(OUT_WORDS);
    localparam logic [9:0]    IN_LAST      = 10'(IN_WORDS - 1);
    localparam logic [9:0]    OUT_LAST     = 10'(OUT_WORDS - 1);
    localparam logic [9:0]    OUT_FULL     = 10'(OUT_WORDS);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [9:0]          tx_idx_q, tx_idx_d;
    logic [9:0]          rx_count_q, rx_count_d;
    logic                err_q, err_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [DATA_RES-1:0] rd_data_q;

    logic [DATA_RES-1:0] frame_q  [IN_WORDS];
    logic [DATA_RES-1:0] result_q [OUT_WORDS];

    logic tx_valid, tx_last, tx_fire;
    logic rx_ready, rx_fire, rx_is_last;
    logic wr_ok, rd_ok;

    assign tx_valid   = (state_q == S_SEND);
    assign tx_last    = tx_valid && (tx_idx_q == IN_LAST);
    assign tx_fire    = tx_valid && m_axis_tready;
    assign rx_ready   = ((state_q == S_SEND) || (state_q == S_DRAIN)) &&
                        ({1'b0, rx_count_q} < OUT_LIMIT);
    assign rx_fire    = s_axis_tvalid && rx_ready;
    assign rx_is_last = (rx_count_q == OUT_LAST);
    assign wr_ok      = (state_q == S_IDLE) && wr_en_i && ({1'b0, wr_addr_i} < IN_LIMIT);
    assign rd_ok      = ({1'b0, rd_addr_i} < OUT_LIMIT);

    // Pixel data is a direct view of the frame buffer; it cannot change
    // during SEND because writes are only accepted in IDLE, so a stalled
    // beat stays stable without an output register.
    assign m_axis_tvalid = tx_valid;
    assign m_axis_tlast  = tx_last;
    assign m_axis_tdata  = tx_valid ? frame_q[tx_idx_q[FAW-1:0]] : '0;
    assign s_axis_tready = rx_ready;
    assign busy_o        = (state_q == S_SEND) || (state_q == S_DRAIN);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign rx_count_o    = rx_count_q;
    assign rd_data_o     = rd_data_q;

    // Next-state logic: frame sequencing, result counting, error and timeout.
    always_comb begin
        state_d    = state_q;
        tx_idx_d   = tx_idx_q;
        rx_count_d = rx_count_q;
        err_d      = err_q;
        timer_d    = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_SEND;
                    tx_idx_d   = '0;
                    rx_count_d = '0;
                    err_d      = 1'b0;
                    timer_d    = '0;
                end
            end
            S_SEND: begin
                if (tx_fire) begin
                    if (tx_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        tx_idx_d = tx_idx_q + 10'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (rx_count_q == OUT_FULL) begin
                    state_d = S_DONE;
                end else if (rx_fire) begin
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (rx_fire) begin
            rx_count_d = rx_count_q + 10'd1;
            if (s_axis_tlast != rx_is_last) begin
                err_d = 1'b1;
            end
        end
    end

    // Control registers; reset aborts any frame in progress.
    always_ff @(posedge clk_i or posedge resetn_i) begin
        if (resetn_i) begin
            state_q    <= S_IDLE;
            tx_idx_q   <= '0;
            rx_count_q <= '0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            tx_idx_q   <= tx_idx_d;
            rx_count_q <= rx_count_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
        end
    end

    // Frame buffer write port, open only in IDLE; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            frame_q[wr_addr_i[FAW-1:0]] <= wr_data_i;
        end
    end

    // Result buffer capture of each accepted result beat; survives reset.
    always_ff @(posedge clk_i) begin
        if (rx_fire) begin
            result_q[rx_count_q[RAW-1:0]] <= s_axis_tdata;
        end
    end

    // Registered result read port, usable in every state.
    always_ff @(posedge clk_i or posedge resetn_i) begin
        if (resetn_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_ok ? result_q[rd_addr_i[RAW-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_img_stream_driver.sv
// Self-checking bench for img_stream_driver on a 4x4 frame with a 3x3
// kernel (16 pixels out, 4 results back), short DRAIN timeout.
module tb_img_stream_driver;

    localparam int unsigned DW   = 8;
    localparam int unsigned IMD  = 4;
    localparam int unsigned KW   = 3;
    localparam int unsigned TO   = 20;
    localparam int unsigned INW  = IMD * IMD;
    localparam int unsigned OUTW = (IMD - KW + 1) * (IMD - KW + 1);

    logic          clk_i = 1'b0;
    logic          resetn_i;
    logic          wr_en_i;
    logic [9:0]    wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          start_i;
    logic [9:0]    rd_addr_i;
    logic [DW-1:0] rd_data_o;
    logic          busy_o, done_o, err_o;
    logic [9:0]    rx_count_o;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;

    int n_cmp = 0;
    int n_mis = 0;

    logic [DW-1:0] frame_m [INW];
    logic [DW-1:0] res_v   [OUTW];
    logic [DW-1:0] res_old [OUTW];

    img_stream_driver #(
        .DATA_RES    (DW),
        .IM_DIM      (IMD),
        .KERNEL_WIDTH(KW),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .start_i      (start_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rx_count_o   (rx_count_o),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tdata (s_axis_tdata)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tlast"}, m_axis_tlast, 0);
        chk({tag, "_tdata"}, m_axis_tdata, 0);
        chk({tag, "_s_tready"}, s_axis_tready, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_rx_count"}, rx_count_o, 0);
        chk({tag, "_rd_data"}, rd_data_o, 0);
    endtask

    // Fill the frame with random pixels, then try writes outside the frame
    // that must not alias onto real addresses.
    task automatic load_frame();
        for (int i = 0; i < INW; i++) begin
            frame_m[i] = DW'($urandom);
            wr_en_i    = 1'b1;
            wr_addr_i  = 10'(i);
            wr_data_i  = frame_m[i];
            @(negedge clk_i);
        end
        for (int i = 0; i < 4; i++) begin
            wr_en_i   = 1'b1;
            wr_addr_i = (i == 3) ? 10'd1023 : 10'(INW + i * 5);
            wr_data_i = DW'($urandom);
            @(negedge clk_i);
        end
        wr_en_i = 1'b0;
    endtask

    task automatic rand_res();
        for (int i = 0; i < OUTW; i++) res_v[i] = DW'($urandom);
    endtask

    task automatic read_back(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr_i = 10'(i);
            @(negedge clk_i);
            chk(tag, rd_data_o, res_v[i]);
        end
    endtask

    // One full frame. tr_mode: 0 tready always high, 1 toggling, 2 random.
    // The sink offers n_res beats (values res_v), tlast on beat tlast_pos.
    // exp_gap: cycles from the tlast pixel beat to done_o (-1: not checked).
    task automatic run_frame(input int tr_mode, input int n_res, input int tlast_pos,
                             input bit eager, input int exp_gap, input bit poke);
        int  pix, got, first_cyc, last_cyc, done_cyc;
        bit  tog, rdy, done_seen, exp_err;
        pix = 0; got = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        tog = 1'b1; done_seen = 1'b0;
        exp_err = (n_res < int'(OUTW)) || (tlast_pos != int'(OUTW) - 1);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("start_rx_count", rx_count_o, 0);
        chk("start_err_clear", err_o, 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done_o === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                break;
            end
            chk("busy", busy_o, 1);
            chk("m_tvalid", m_axis_tvalid, pix < int'(INW));
            chk("rx_count", rx_count_o, got);
            chk("s_tready", s_axis_tready, got < int'(OUTW));
            case (tr_mode)
                0:       rdy = 1'b1;
                1:       rdy = tog;
                default: rdy = 1'($urandom);
            endcase
            tog = ~tog;
            m_axis_tready = rdy;
            if (m_axis_tvalid === 1'b1 && pix < int'(INW)) begin
                chk("m_tdata", m_axis_tdata, frame_m[pix]);
                chk("m_tlast", m_axis_tlast, pix == int'(INW) - 1);
                if (rdy) begin
                    if (pix == 0) first_cyc = cyc;
                    if (pix == int'(INW) - 1) last_cyc = cyc;
                    pix++;
                end
            end
            if (got < n_res && (eager || $urandom_range(1, 0) == 1)) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = res_v[got];
                s_axis_tlast  = (got == tlast_pos);
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                s_axis_tdata  = DW'($urandom);
            end
            if (s_axis_tvalid && s_axis_tready === 1'b1) got++;
            wr_en_i   = poke && (cyc == 3);
            start_i   = poke && (cyc == 3);
            wr_addr_i = 10'd12;
            wr_data_i = ~frame_m[12];
            @(negedge clk_i);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        wr_en_i       = 1'b0;
        start_i       = 1'b0;
        chk("done_seen", done_seen, 1);
        if (done_seen) begin
            chk("done_busy", busy_o, 0);
            chk("done_err", err_o, exp_err);
            chk("done_rx_count", rx_count_o, n_res);
            chk("done_tvalid", m_axis_tvalid, 0);
            chk("pixels_sent", pix, INW);
            if (tr_mode == 0) chk("burst_len", last_cyc - first_cyc, INW - 1);
            if (exp_gap >= 0) chk("drain_cycles", done_cyc - last_cyc, exp_gap);
            @(negedge clk_i);
            chk("done_single", done_o, 0);
            chk("idle_busy", busy_o, 0);
            chk("err_sticky", err_o, exp_err);
            read_back("rd_data", n_res);
        end
    endtask

    initial begin
        resetn_i = 1'b1;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; start_i = 1'b0;
        rd_addr_i = '0; m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        repeat (3) @(negedge clk_i);
        chk_zero("reset");
        resetn_i = 1'b0;
        @(negedge clk_i);

        // Nominal frame, results A0..A3, pixels back-to-back.
        load_frame();
        for (int i = 0; i < int'(OUTW); i++) res_v[i] = DW'(8'hA0 + i);
        run_frame(0, 4, 3, 1'b1, 2, 1'b0);
        rd_addr_i = 10'd2;
        @(negedge clk_i);
        chk("rd_addr2", rd_data_o, 8'hA2);

        // Back-pressure toggling every cycle.
        rand_res();
        run_frame(1, 4, 3, 1'b0, -1, 1'b0);

        // Only two results: DRAIN must time out.
        rand_res();
        run_frame(0, 2, 3, 1'b1, int'(TO) + 1, 1'b0);

        // Early tlast on the third result.
        rand_res();
        run_frame(2, 4, 2, 1'b0, -1, 1'b0);

        // Reset at pixel 7, then rerun with the retained frame.
        for (int i = 0; i < int'(OUTW); i++) res_old[i] = res_v[i];
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 7; k++) @(negedge clk_i);
        chk("pre_reset_pix7", m_axis_tdata, frame_m[7]);
        resetn_i = 1'b1;
        m_axis_tready = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk_i);
        chk_zero("mid_reset");
        resetn_i = 1'b0;
        for (int i = 0; i < int'(OUTW); i++) res_v[i] = res_old[i];
        read_back("retained_result", OUTW);
        rand_res();
        run_frame(0, 4, 3, 1'b1, 2, 1'b0);

        // Writes and start pulses during SEND are ignored.
        rand_res();
        run_frame(2, 4, 3, 1'b0, -1, 1'b1);
        repeat (5) begin
            chk("no_restart_busy", busy_o, 0);
            chk("no_restart_done", done_o, 0);
            @(negedge clk_i);
        end
        rand_res();
        run_frame(0, 4, 3, 1'b1, 2, 1'b0);

        // A few fully random frames.
        for (int f = 0; f < 3; f++) begin
            load_frame();
            rand_res();
            run_frame(2, 4, 3, 1'b0, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
